// File: rtl/simon_seq_ctrl.sv
// rtl/simon_seq_ctrl.sv - memory-game sequence controller (grow, play back, check answers)
//
// Grows a random symbol sequence by one symbol per round, plays it back as
// on/off phases paced by TIMER_PULSE, then checks the player's answers. The
// game ends on a wrong answer, on TIMEOUT pulses without an answer, or when
// the sequence buffer is full (a win). It also tracks the score and the high
// score.
//
// Parameters:
//   SYM_W    symbol width (2^SYM_W colours)
//   DEPTH    maximum sequence length; filling it wins the game (>= 2)
//   TIMEOUT  TIMER_PULSEs allowed between answers (>= 1)
//   CNT_W    width of the length / score counters
//
// Ports:
//   CLK          clock, single domain
//   RST          synchronous active-high reset
//   START        level, sampled only while idle
//   RAND         random symbol, sampled when a symbol is appended
//   TIMER_PULSE  one-cycle tick pacing the display and the answer timeout
//   IN           encoded player answer, qualified by IN_VALID
//   IN_VALID     one-cycle strobe per answer (already synced/debounced)
//   OUT          symbol being shown
//   OUT_ENA      display/sound enable
//   WIN, LOSE    game result flags, held until the next START
//   HS           one-cycle new-high-score pulse
//   SCORE        rounds completed in the current or last game
//   HIGH_SCORE   best SCORE since reset
//   BUSY         high whenever the controller is not idle

module simon_seq_ctrl #(
    parameter int SYM_W   = 2,
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [SYM_W-1:0] RAND,
    input  logic             TIMER_PULSE,
    input  logic [SYM_W-1:0] IN,
    input  logic             IN_VALID,
    output logic [SYM_W-1:0] OUT,
    output logic             OUT_ENA,
    output logic             WIN,
    output logic             LOSE,
    output logic             HS,
    output logic [CNT_W-1:0] SCORE,
    output logic [CNT_W-1:0] HIGH_SCORE,
    output logic             BUSY
);

    // Address width of the symbol store; CNT_W is always at least this wide.
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_INPUT,
        S_WIN,
        S_LOSE,
        S_END
    } state_t;

    state_t state;

    // Symbol store: contents are only ever read below len, so no reset.
    logic [SYM_W-1:0] stack [DEPTH];

    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] idx;
    logic [TMO_W-1:0] tmo;

    logic             last_sym;
    logic [CNT_W-1:0] idx_inc;
    logic             stack_wr;
    logic             answer_ok;

    assign last_sym  = (idx == len - CNT_ONE);
    assign idx_inc   = idx + CNT_ONE;
    assign stack_wr  = (state == S_ADD) && (len != DEPTH_C);
    assign answer_ok = (IN == stack[idx[ADDR_W-1:0]]);
    assign BUSY      = (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (stack_wr) begin
            stack[len[ADDR_W-1:0]] <= RAND;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            OUT        <= '1;
            OUT_ENA    <= 1'b0;
            WIN        <= 1'b0;
            LOSE       <= 1'b0;
            HS         <= 1'b0;
            SCORE      <= '0;
            HIGH_SCORE <= '0;
            len        <= '0;
            idx        <= '0;
            tmo        <= '0;
        end else begin
            HS <= 1'b0;

            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (START) begin
                        len   <= '0;
                        SCORE <= '0;
                        WIN   <= 1'b0;
                        LOSE  <= 1'b0;
                        state <= S_ADD;
                    end
                end

                S_ADD: begin
                    if (len == DEPTH_C) begin
                        state <= S_WIN;
                    end else begin
                        len     <= len + CNT_ONE;
                        idx     <= '0;
                        // On the first round the store is written this same
                        // cycle, so the first symbol comes straight from RAND.
                        OUT     <= (len == CNT_ZERO) ? RAND : stack[0];
                        OUT_ENA <= 1'b1;
                        state   <= S_SHOW_ON;
                    end
                end

                S_SHOW_ON: begin
                    if (TIMER_PULSE) begin
                        OUT_ENA <= 1'b0;
                        state   <= S_SHOW_OFF;
                    end
                end

                S_SHOW_OFF: begin
                    if (TIMER_PULSE) begin
                        if (last_sym) begin
                            idx   <= '0;
                            tmo   <= '0;
                            state <= S_INPUT;
                        end else begin
                            idx     <= idx_inc;
                            OUT     <= stack[idx_inc[ADDR_W-1:0]];
                            OUT_ENA <= 1'b1;
                            state   <= S_SHOW_ON;
                        end
                    end
                end

                S_INPUT: begin
                    // An answer wins over a coincident tick and restarts the
                    // timeout window.
                    if (IN_VALID) begin
                        if (answer_ok) begin
                            tmo <= '0;
                            if (last_sym) begin
                                SCORE <= SCORE + CNT_ONE;
                                state <= S_ADD;
                            end else begin
                                idx <= idx_inc;
                            end
                        end else begin
                            state <= S_LOSE;
                        end
                    end else if (TIMER_PULSE) begin
                        tmo <= tmo + TMO_ONE;
                        if (tmo == TMO_LAST) begin
                            state <= S_LOSE;
                        end
                    end
                end

                S_WIN: begin
                    WIN   <= 1'b1;
                    state <= S_END;
                end

                S_LOSE: begin
                    LOSE  <= 1'b1;
                    state <= S_END;
                end

                S_END: begin
                    // Ties do not count as a new high score.
                    if (SCORE > HIGH_SCORE) begin
                        HIGH_SCORE <= SCORE;
                        HS         <= 1'b1;
                    end
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// tb/tb_simon_seq_ctrl.sv - self-checking bench for simon_seq_ctrl

module tb_simon_seq_ctrl;

    localparam int SYM_W   = 2;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 3;
    localparam int CNT_W   = 3;

    // Game-ending kinds used by the stimulus tables.
    localparam int K_WRONG   = 0;
    localparam int K_TIMEOUT = 1;
    localparam int K_WIN     = 2;

    logic             CLK;
    logic             RST;
    logic             START;
    logic [SYM_W-1:0] RAND;
    logic             TIMER_PULSE;
    logic [SYM_W-1:0] IN;
    logic             IN_VALID;
    logic [SYM_W-1:0] OUT;
    logic             OUT_ENA;
    logic             WIN;
    logic             LOSE;
    logic             HS;
    logic [CNT_W-1:0] SCORE;
    logic [CNT_W-1:0] HIGH_SCORE;
    logic             BUSY;

    simon_seq_ctrl #(
        .SYM_W  (SYM_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .RAND       (RAND),
        .TIMER_PULSE(TIMER_PULSE),
        .IN         (IN),
        .IN_VALID   (IN_VALID),
        .OUT        (OUT),
        .OUT_ENA    (OUT_ENA),
        .WIN        (WIN),
        .LOSE       (LOSE),
        .HS         (HS),
        .SCORE      (SCORE),
        .HIGH_SCORE (HIGH_SCORE),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int ok_rounds;
        int kind;
        bit stress;
        int score;
        bit win;
        bit lose;
        bit hs;
        int high;
    } game_vec_t;

    game_vec_t        vecs [6];
    int               checks;
    int               failures;
    int               hs_model;
    logic [SYM_W-1:0] seq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse();
        TIMER_PULSE = 1'b1;
        tick();
        TIMER_PULSE = 1'b0;
    endtask

    task automatic idle_rand();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic wait_ena(input logic v);
        for (int i = 0; i < 50; i++) begin
            if (OUT_ENA === v) break;
            tick();
        end
        check("wait_out_ena", OUT_ENA, v);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (BUSY === 1'b0) break;
            tick();
        end
        check("wait_idle", BUSY, 0);
    endtask

    task automatic answer(input logic [SYM_W-1:0] v, input bit with_pulse);
        IN          = v;
        IN_VALID    = 1'b1;
        TIMER_PULSE = with_pulse;
        tick();
        IN_VALID    = 1'b0;
        TIMER_PULSE = 1'b0;
    endtask

    // Play back the whole expected sequence; leaves the controller in INPUT.
    task automatic show_round(input bit stress);
        for (int i = 0; i < seq.size(); i++) begin
            wait_ena(1'b1);
            check("show_sym", OUT, seq[i]);
            if (stress) begin
                // Answers and START during playback must be ignored.
                IN       = ~seq[i];
                IN_VALID = 1'b1;
                START    = 1'b1;
                tick();
                IN_VALID = 1'b0;
                START    = 1'b0;
                check("show_ignore_in", OUT_ENA, 1);
            end
            idle_rand();
            pulse();
            check("show_off", OUT_ENA, 0);
            check("show_off_hold", OUT, seq[i]);
            idle_rand();
            pulse();
        end
    endtask

    task automatic start_game();
        RAND = SYM_W'($urandom);
        seq.delete();
        seq.push_back(RAND);
        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_score_clr", SCORE, 0);
        check("start_flags_clr", {WIN, LOSE}, 0);
    endtask

    // Play one game: ok_rounds rounds answered correctly, then the given end.
    task automatic play_game(input int ok_rounds, input int kind, input bit stress);
        start_game();
        for (int r = 1; r <= DEPTH; r++) begin
            show_round(stress);
            if (kind != K_WIN && r == ok_rounds + 1) begin
                int k;
                k = $urandom_range(0, r - 1);
                for (int j = 0; j < k; j++) begin
                    answer(seq[j], 1'b0);
                    idle_rand();
                end
                if (kind == K_WRONG) begin
                    answer(seq[k] ^ SYM_W'($urandom_range(1, (1 << SYM_W) - 1)), 1'b0);
                end else begin
                    repeat (TIMEOUT - 1) begin
                        pulse();
                        idle_rand();
                    end
                    repeat (3) tick();
                    check("no_early_timeout", {LOSE, BUSY}, 2'b01);
                    pulse();
                end
                return;
            end
            for (int j = 0; j < r; j++) begin
                if (stress) begin
                    // Full timeout window minus one, then an answer that
                    // coincides with a tick: must not lose.
                    repeat (TIMEOUT - 1) pulse();
                end
                if (j == r - 1) begin
                    RAND = SYM_W'($urandom);
                    if (r < DEPTH) seq.push_back(RAND);
                end
                answer(seq[j], stress);
                if (j < r - 1) idle_rand();
            end
        end
    endtask

    task automatic end_check(input int score, input bit win, input bit lose,
                             input bit hs, input int high);
        wait_idle();
        check("end_win", WIN, win);
        check("end_lose", LOSE, lose);
        check("end_score", SCORE, score);
        check("end_hs", HS, hs);
        check("end_high", HIGH_SCORE, high);
        tick();
        check("hs_one_cycle", HS, 0);
        check("flags_hold", {WIN, LOSE}, {win, lose});
    endtask

    initial begin
        vecs[0] = '{1, K_WRONG,   1'b0, 1, 1'b0, 1'b1, 1'b1, 1};
        vecs[1] = '{2, K_TIMEOUT, 1'b1, 2, 1'b0, 1'b1, 1'b1, 2};
        vecs[2] = '{1, K_WRONG,   1'b0, 1, 1'b0, 1'b1, 1'b0, 2};
        vecs[3] = '{2, K_WRONG,   1'b1, 2, 1'b0, 1'b1, 1'b0, 2};
        vecs[4] = '{0, K_WIN,     1'b1, 4, 1'b1, 1'b0, 1'b1, 4};
        vecs[5] = '{0, K_TIMEOUT, 1'b0, 0, 1'b0, 1'b1, 1'b0, 4};

        checks      = 0;
        failures    = 0;
        hs_model    = 0;
        RST         = 1'b1;
        START       = 1'b0;
        RAND        = '0;
        TIMER_PULSE = 1'b0;
        IN          = '0;
        IN_VALID    = 1'b0;

        // Reset state.
        repeat (3) tick();
        RST = 1'b0;
        check("rst_busy", BUSY, 0);
        check("rst_out", OUT, 3);
        check("rst_out_ena", OUT_ENA, 0);
        check("rst_flags", {WIN, LOSE, HS}, 0);
        check("rst_score", SCORE, 0);
        check("rst_high", HIGH_SCORE, 0);

        // IN_VALID while idle is not an answer and does not start anything.
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        check("idle_in_ignored", BUSY, 0);

        // First-symbol latency: ADD one cycle after START, display the next.
        RAND  = 2'd2;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("lat_add_busy", BUSY, 1);
        check("lat_add_ena", OUT_ENA, 0);
        tick();
        check("lat_show_ena", OUT_ENA, 1);
        check("lat_show_out", OUT, 2);
        tick();
        check("lat_show_hold", OUT_ENA, 1);
        pulse();
        check("lat_off", OUT_ENA, 0);
        pulse();
        answer(2'd1, 1'b0);
        end_check(0, 1'b0, 1'b1, 1'b0, 0);

        // Table-driven games.
        for (int v = 0; v < 6; v++) begin
            play_game(vecs[v].ok_rounds, vecs[v].kind, vecs[v].stress);
            end_check(vecs[v].score, vecs[v].win, vecs[v].lose, vecs[v].hs, vecs[v].high);
        end

        // Reset in the middle of playback with a nonzero high score.
        start_game();
        tick();
        check("mid_show_ena", OUT_ENA, 1);
        check("mid_high", HIGH_SCORE, 4);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_out", OUT, 3);
        check("mid_rst_ena", OUT_ENA, 0);
        check("mid_rst_high", HIGH_SCORE, 0);
        check("mid_rst_score", SCORE, 0);
        check("mid_rst_flags", {WIN, LOSE, HS}, 0);

        // Randomised games against the game-level model.
        for (int g = 0; g < 24; g++) begin
            int kind;
            int ok;
            int score;
            bit hs;
            bit stress;
            kind   = $urandom_range(0, 2);
            ok     = $urandom_range(0, DEPTH - 1);
            stress = 1'($urandom);
            score  = (kind == K_WIN) ? DEPTH : ok;
            hs     = (score > hs_model);
            if (hs) hs_model = score;
            play_game(ok, kind, stress);
            end_check(score, kind == K_WIN, kind != K_WIN, hs, hs_model);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simon_seq_ctrl.md
# simon_seq_ctrl

Parametrised game-sequence controller for the memory ("repeat the colour sequence") game. It grows a random symbol sequence by one symbol per round and plays it back to the display/sound path. It then checks the player's answers and ends the game on a wrong answer, an input timeout, or a full sequence buffer. It sits between the input encoder/synchroniser, the random source, the shared timer-pulse generator, and the display/score logic, and adds configurable symbol width, depth, input timeout, on/off display phases and score/high-score tracking.

## Interface
- SYM_W, default 2: symbol width; 2^SYM_W colours.
- DEPTH, default 32: maximum sequence length (≥2); reaching it wins the game.
- TIMEOUT, default 8: TIMER_PULSEs allowed between answers before the game is lost (≥1).
- CNT_W, default $clog2(DEPTH+1): width of the length and score counters.

- CLK  in  1  clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- START  in  1  level; sampled only in IDLE.
- RAND  in  SYM_W  random symbol; sampled in ADD.
- TIMER_PULSE  in  1  one-cycle tick pacing display and timeout.
- IN  in  SYM_W  encoded player answer; valid when IN_VALID is high.
- IN_VALID  in  1  one-cycle strobe per answer, already synced and debounced.
- OUT  out  SYM_W  symbol being shown.
- OUT_ENA  out  1  display/sound enable.
- WIN  out  1  game-won flag.
- LOSE  out  1  game-lost flag.
- HS  out  1  one-cycle new-high-score pulse.
- SCORE  out  CNT_W  rounds completed in the current or last game.
- HIGH_SCORE  out  CNT_W  best SCORE since reset.
- BUSY  out  1  high in every state except IDLE.

## Operation
- Storage: DEPTH × SYM_W symbol array (not reset). Registers: len (CNT_W), idx (CNT_W), tmo ($clog2(TIMEOUT+1)).
- Reset values:
  - state = IDLE
  - OUT = all ones
  - OUT_ENA, WIN, LOSE, HS = 0
  - SCORE, HIGH_SCORE, len, idx, tmo = 0
- States and transitions:
  - IDLE: idx = 0. If START: clear len, SCORE, WIN and LOSE, then go to ADD. WIN/LOSE hold their last value until then.
  - ADD:
    - If len == DEPTH, go to WIN_S.
    - Otherwise write stack[len] = RAND, len = len + 1, idx = 0, then go to SHOW_ON.
  - SHOW_ON: load OUT = stack[idx] on entry; OUT_ENA = 1 for the whole state. On TIMER_PULSE go to SHOW_OFF.
  - SHOW_OFF: OUT_ENA = 0 and OUT holds. On TIMER_PULSE:
    - If idx == len-1: idx = 0, tmo = 0, go to INPUT.
    - Otherwise idx = idx + 1 and go to SHOW_ON.
  - INPUT:
    - IN_VALID with IN == stack[idx]: tmo = 0.
      - If idx == len-1: SCORE = SCORE + 1, go to ADD.
      - Otherwise idx = idx + 1.
    - IN_VALID with a mismatch: go to LOSE_S.
    - No IN_VALID, TIMER_PULSE: tmo = tmo + 1. If tmo == TIMEOUT-1, go to LOSE_S.
  - WIN_S: WIN = 1, go to END.
  - LOSE_S: LOSE = 1, go to END.
  - END: if SCORE > HIGH_SCORE, set HIGH_SCORE = SCORE and pulse HS for 1 cycle. Go to IDLE.
- Arithmetic is unsigned, and no counter ever wraps. len ≤ DEPTH, SCORE ≤ DEPTH, idx < len.
- A WIN always ends with SCORE == DEPTH.

## Timing
- START sampled in IDLE at cycle t:
  - ADD at t+1.
  - SHOW_ON, and OUT_ENA = 1 with OUT valid, at t+2.
- Each displayed symbol lasts one TIMER_PULSE interval on, then one interval off. The SHOW state changes on the cycle after the pulse.
- Simultaneous IN_VALID and TIMER_PULSE in INPUT: IN_VALID takes priority and tmo clears.
- IN_VALID outside INPUT is ignored; it does not count as an answer.
- START outside IDLE is ignored.
- HS is high exactly one cycle: the cycle after END.
- A game ending with SCORE equal to HIGH_SCORE produces no HS pulse.
- RST mid-game returns to IDLE next cycle with all reset values, including HIGH_SCORE = 0 and OUT_ENA = 0.

## Test plan
- SYM_W=2, DEPTH=4: START with RAND=2. → OUT_ENA rises 2 cycles later with OUT=2, falls after one TIMER_PULSE, then the controller enters INPUT.
- Same setup, answer IN=2 in round 1, then give a wrong answer in round 2. → LOSE=1, SCORE=1, HIGH_SCORE=1, one HS pulse.
- DEPTH=4, all answers correct for 4 rounds. → WIN=1, LOSE=0, SCORE=4, HS pulses. Playback of round 4 shows the 4 stored symbols in order.
- In INPUT, give no answers, TIMEOUT=3. → LOSE after the 3rd TIMER_PULSE. Repeat with IN_VALID coincident with the 2nd pulse. → no loss, tmo restarts.
- Second game scoring 1 after a first game scoring 2. → HIGH_SCORE stays 2, no HS. Also check IN_VALID during SHOW_ON is ignored.
- RST asserted during SHOW_ON with a nonzero HIGH_SCORE. → next cycle: IDLE, OUT=all ones, OUT_ENA=0, HIGH_SCORE=0, BUSY=0.
